// File: rtl/dm_bus_bridge.sv
// Data-memory port to request/grant/response bus bridge: byte enables, lane replication, load extension.
// Optional DM_BUS_TIMEOUT_EN bounds REQ+RSP to TIMEOUT_CYCLES cycles, then forces an error completion.
module dm_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_DM_addr,
    input  logic [31:0] i_DM_wd,
    input  logic        i_DM_wen,
    input  logic        i_DM_ren,
    input  logic [2:0]  i_DM_funct3,
    output logic [31:0] o_DM_rd,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_BUS_req,
    output logic        o_BUS_we,
    output logic [31:0] o_BUS_addr,
    output logic [31:0] o_BUS_wdata,
    output logic [3:0]  o_BUS_be,
    input  logic        i_BUS_gnt,
    input  logic        i_BUS_rvalid,
    input  logic [31:0] i_BUS_rdata,
    input  logic        i_BUS_err
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t      state;
    logic        access;
    logic        is_store;
    logic        legal;
    logic        aligned;
    logic        fault;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        ld_q;

    always_comb begin
        access    = i_DM_wen | i_DM_ren;
        is_store  = i_DM_wen;
        legal     = 1'b0;
        aligned   = 1'b1;
        be_nxt    = 4'b0000;
        wdata_nxt = i_DM_wd;
        case (i_DM_funct3)
            3'b000, 3'b100: begin
                legal     = !(is_store && i_DM_funct3[2]);
                be_nxt    = 4'b0001 << i_DM_addr[1:0];
                wdata_nxt = {4{i_DM_wd[7:0]}};
            end
            3'b001, 3'b101: begin
                legal     = !(is_store && i_DM_funct3[2]);
                aligned   = !i_DM_addr[0];
                be_nxt    = 4'b0011 << i_DM_addr[1:0];
                wdata_nxt = {2{i_DM_wd[15:0]}};
            end
            3'b010: begin
                legal     = 1'b1;
                aligned   = (i_DM_addr[1:0] == 2'b00);
                be_nxt    = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
        fault = access && !(legal && aligned);
    end

    // The core sees the stall in the very cycle it presents the access.
    assign o_stall      = (state == IDLE) ? (access && !fault) : (state != DONE);
    assign o_misaligned = (state == IDLE) && fault;

    function automatic logic [31:0] load_ext(input logic [31:0] d,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {24'd0, sh[7:0]};
            3'b101:  load_ext = {16'd0, sh[15:0]};
            default: load_ext = d;
        endcase
    endfunction

`ifdef DM_BUS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt;
    logic          expire;

    // cnt counts cycles already spent, so expiry fires on the TIMEOUT_CYCLES-th cycle.
    assign expire = ((state == REQ) || (state == RSP))
                    && (cnt == CW'(TIMEOUT_CYCLES - 1))
                    && !((state == RSP) && i_BUS_rvalid);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_BUS_req   <= 1'b0;
            o_BUS_we    <= 1'b0;
            o_BUS_addr  <= 32'd0;
            o_BUS_wdata <= 32'd0;
            o_BUS_be    <= 4'd0;
            o_DM_rd     <= 32'd0;
            o_bus_err   <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            ld_q        <= 1'b0;
`ifdef DM_BUS_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            o_bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !fault) begin
                        o_BUS_req   <= 1'b1;
                        o_BUS_we    <= is_store;
                        o_BUS_addr  <= {i_DM_addr[31:2], 2'b00};
                        o_BUS_wdata <= wdata_nxt;
                        o_BUS_be    <= be_nxt;
                        f3_q        <= i_DM_funct3;
                        off_q       <= i_DM_addr[1:0];
                        ld_q        <= !is_store;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (i_BUS_gnt) begin
                        o_BUS_req <= 1'b0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (i_BUS_rvalid) begin
                        state <= DONE;
                        if (i_BUS_err) begin
                            o_bus_err <= 1'b1;
                            o_DM_rd   <= 32'd0;
                        end else if (ld_q) begin
                            o_DM_rd <= load_ext(i_BUS_rdata, off_q, f3_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef DM_BUS_TIMEOUT_EN
            if (state == IDLE) begin
                cnt <= '0;
            end else if ((state == REQ) || (state == RSP)) begin
                cnt <= cnt + 1'b1;
            end
            if (expire) begin
                state     <= DONE;
                o_BUS_req <= 1'b0;
                o_bus_err <= 1'b1;
                if (ld_q) begin
                    o_DM_rd <= 32'd0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Bench for dm_bus_bridge: vector table with a bus responder, DONE-side scoreboard, reset and no-grant sequences.
module tb_dm_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dm_addr, dm_wd, dm_rd, bus_addr, bus_wdata, bus_rdata;
    logic        dm_wen, dm_ren, stall, misaligned, bus_err_o;
    logic [2:0]  dm_f3;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err_i;
    logic [3:0]  bus_be;

    always #5 clk = ~clk;

    dm_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_DM_addr(dm_addr), .i_DM_wd(dm_wd), .i_DM_wen(dm_wen), .i_DM_ren(dm_ren),
        .i_DM_funct3(dm_f3), .o_DM_rd(dm_rd), .o_stall(stall), .o_misaligned(misaligned),
        .o_bus_err(bus_err_o), .o_BUS_req(bus_req), .o_BUS_we(bus_we), .o_BUS_addr(bus_addr),
        .o_BUS_wdata(bus_wdata), .o_BUS_be(bus_be), .i_BUS_gnt(bus_gnt),
        .i_BUS_rvalid(bus_rvalid), .i_BUS_rdata(bus_rdata), .i_BUS_err(bus_err_i)
    );

    typedef struct {
        logic        wen, ren;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        int          gdly, rdly;
        logic [31:0] rdata;
        logic        err;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wdata, baddr, rd;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] rd;
        logic        err;
        int          stall;
    } exp_t;

    localparam int NV = 16;
    vec_t vecs[NV];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;
    int   stall_cnt = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic ren, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input int gdly, input int rdly, input logic [31:0] rdata,
                                input logic err, input logic fault, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] baddr,
                                input logic [31:0] rd);
        vec_t v;
        v.wen = wen; v.ren = ren; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.gdly = gdly; v.rdly = rdly; v.rdata = rdata; v.err = err;
        v.fault = fault; v.be = be; v.wdata = wdata; v.baddr = baddr; v.rd = rd;
        return v;
    endfunction

    // Scoreboard side: a completion is either a misaligned pulse or the falling edge of stall (DONE).
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (misaligned || (!stall && stall_cnt > 0)) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: completion with empty queue, rd %h", dm_rd);
                end else begin
                    e = sb_q.pop_front();
                    check32("fault", {31'd0, misaligned}, {31'd0, e.fault});
                    if (e.fault) begin
                        check32("fault_stall", {31'd0, stall}, 32'd0);
                    end else begin
                        check32("load_data", dm_rd, e.rd);
                        check32("bus_err", {31'd0, bus_err_o}, {31'd0, e.err});
                        check32("stall_cycles", stall_cnt, e.stall);
                    end
                end
            end
            stall_cnt = stall ? stall_cnt + 1 : 0;
        end
    end

    task automatic apply_vec(input vec_t v);
        exp_t e;
        dm_wen = v.wen; dm_ren = v.ren; dm_f3 = v.f3; dm_addr = v.addr; dm_wd = v.wd;
        e.fault = v.fault; e.rd = v.rd; e.err = v.err;
        e.stall = v.fault ? 0 : 3 + v.gdly + v.rdly;
        sb_q.push_back(e);
        if (v.fault) begin
            @(negedge clk);
            check32("fault_no_req", {31'd0, bus_req}, 32'd0);
            @(posedge clk); #1;
            dm_wen = 1'b0; dm_ren = 1'b0;
            @(negedge clk);
            check32("fault_no_req_next", {31'd0, bus_req}, 32'd0);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        for (int i = 0; i < v.gdly; i++) begin
            @(negedge clk);
            check32("req_held", {31'd0, bus_req}, 32'd1);
            check32("addr_stable", bus_addr, v.baddr);
            check32("be_stable", {28'd0, bus_be}, {28'd0, v.be});
            check32("wdata_stable", bus_wdata, v.wdata);
            @(posedge clk); #1;
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        check32("req", {31'd0, bus_req}, 32'd1);
        check32("we", {31'd0, bus_we}, {31'd0, v.wen});
        check32("addr", bus_addr, v.baddr);
        check32("be", {28'd0, bus_be}, {28'd0, v.be});
        check32("wdata", bus_wdata, v.wdata);
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        repeat (v.rdly) begin
            @(posedge clk); #1;
        end
        bus_rvalid = 1'b1; bus_rdata = v.rdata; bus_err_i = v.err;
        @(negedge clk);
        check32("req_dropped", {31'd0, bus_req}, 32'd0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_err_i = 1'b0;
        @(posedge clk); #1;
        dm_wen = 1'b0; dm_ren = 1'b0;
    endtask

    initial begin
        int reqs;
        int guard;
        int held;

        vecs[0]  = mk(0, 1, 3'b010, 32'h100, 32'h0,      0, 0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h0,        32'h100, 32'hDEADBEEF);
        vecs[1]  = mk(0, 1, 3'b000, 32'h103, 32'h0,      0, 0, 32'h80112233, 0, 0, 4'h8, 32'h0,        32'h100, 32'hFFFFFF80);
        vecs[2]  = mk(0, 1, 3'b100, 32'h103, 32'h0,      0, 0, 32'h80112233, 0, 0, 4'h8, 32'h0,        32'h100, 32'h00000080);
        vecs[3]  = mk(1, 0, 3'b001, 32'h202, 32'hABCD,   5, 0, 32'h0,        0, 0, 4'hC, 32'hABCDABCD, 32'h200, 32'h00000080);
        vecs[4]  = mk(0, 1, 3'b010, 32'h101, 32'h0,      0, 0, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0,   32'h0);
        vecs[5]  = mk(1, 0, 3'b000, 32'h101, 32'hA5,     1, 2, 32'h0,        0, 0, 4'h2, 32'hA5A5A5A5, 32'h100, 32'h00000080);
        vecs[6]  = mk(0, 1, 3'b001, 32'h102, 32'h0,      0, 1, 32'h80017FFF, 0, 0, 4'hC, 32'h0,        32'h100, 32'hFFFF8001);
        vecs[7]  = mk(0, 1, 3'b101, 32'h100, 32'h0,      2, 0, 32'h8001F00F, 0, 0, 4'h3, 32'h0,        32'h100, 32'h0000F00F);
        vecs[8]  = mk(0, 1, 3'b010, 32'h200, 32'h0,      0, 0, 32'h12345678, 1, 0, 4'hF, 32'h0,        32'h200, 32'h0);
        vecs[9]  = mk(0, 1, 3'b001, 32'h101, 32'h0,      0, 0, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0,   32'h0);
        vecs[10] = mk(0, 1, 3'b011, 32'h100, 32'h0,      0, 0, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0,   32'h0);
        vecs[11] = mk(1, 0, 3'b100, 32'h100, 32'h0,      0, 0, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0,   32'h0);
        vecs[12] = mk(1, 1, 3'b010, 32'h300, 32'h11223344, 0, 0, 32'h0,      0, 0, 4'hF, 32'h11223344, 32'h300, 32'h0);
        vecs[13] = mk(0, 1, 3'b000, 32'h101, 32'h0,      0, 0, 32'h00007F00, 0, 0, 4'h2, 32'h0,        32'h100, 32'h0000007F);
        vecs[14] = mk(1, 0, 3'b010, 32'h302, 32'h0,      0, 0, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0,   32'h0);
        vecs[15] = mk(0, 1, 3'b110, 32'h100, 32'h0,      0, 0, 32'h0,        0, 1, 4'h0, 32'h0,        32'h0,   32'h0);

        rst = 1'b1;
        dm_addr = 32'd0; dm_wd = 32'd0; dm_wen = 1'b0; dm_ren = 1'b0; dm_f3 = 3'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_err_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check32("rst_req", {31'd0, bus_req}, 32'd0);
        check32("rst_we", {31'd0, bus_we}, 32'd0);
        check32("rst_addr", bus_addr, 32'd0);
        check32("rst_wdata", bus_wdata, 32'd0);
        check32("rst_be", {28'd0, bus_be}, 32'd0);
        check32("rst_rd", dm_rd, 32'd0);
        check32("rst_pulses", {30'd0, bus_err_o, misaligned}, 32'd0);
        check32("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        mon_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            apply_vec(vecs[i]);
        end
        @(negedge clk);
        mon_en = 1'b0;
        check32("sb_drained", sb_q.size(), 32'd0);

        // Reset while waiting for the response; the late response must be ignored.
        @(posedge clk); #1;
        dm_ren = 1'b1; dm_f3 = 3'b010; dm_addr = 32'h100;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        @(negedge clk);
        check32("rsp_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1; dm_ren = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check32("midrst_req", {31'd0, bus_req}, 32'd0);
        check32("midrst_stall", {31'd0, stall}, 32'd0);
        check32("midrst_rd", dm_rd, 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D; bus_err_i = 1'b1;
        @(posedge clk); #1;
        bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_err_i = 1'b0;
        @(negedge clk);
        check32("late_rv_stall", {31'd0, stall}, 32'd0);
        check32("late_rv_err", {31'd0, bus_err_o}, 32'd0);
        check32("late_rv_rd", dm_rd, 32'd0);
        check32("late_rv_req", {31'd0, bus_req}, 32'd0);

        // Grant never arrives.
        @(posedge clk); #1;
        dm_ren = 1'b1; dm_f3 = 3'b010; dm_addr = 32'h400;
        @(posedge clk); #1;
        reqs = 0; guard = 0; held = 0;
`ifdef DM_BUS_TIMEOUT_EN
        while (guard < 40) begin
            @(negedge clk);
            if (!stall) break;
            if (bus_req) reqs++;
            guard++;
            @(posedge clk); #1;
        end
        check32("timeout_reached", {31'd0, (guard < 40)}, 32'd1);
        check32("timeout_req_cycles", reqs, 32'd4);
        check32("timeout_err", {31'd0, bus_err_o}, 32'd1);
        check32("timeout_req", {31'd0, bus_req}, 32'd0);
        check32("timeout_rd", dm_rd, 32'd0);
        @(posedge clk); #1;
        dm_ren = 1'b0;
`else
        repeat (120) begin
            @(negedge clk);
            if (stall && bus_req) held++;
        end
        check32("no_gnt_stall_held", held, 32'd120);
        @(posedge clk); #1;
        rst = 1'b1; dm_ren = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check32("no_gnt_released", {31'd0, stall}, 32'd0);
`endif
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_bus_bridge.md
Name: dm_bus_bridge

Overview:
Sits directly downstream of the core's data-memory port. Converts the core's single-cycle DM request (address, write data, write enable, read enable, funct3) into a registered request/grant/response bus transaction with byte enables. Stalls the core until the response arrives, then returns aligned and sign/zero-extended load data. Flags misaligned accesses and bus errors.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of cycles spent in REQ+RSP before a forced error; used only when DM_BUS_TIMEOUT_EN is defined.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_DM_addr  in  32  core byte address
i_DM_wd  in  32  core store data, right-aligned
i_DM_wen  in  1  store request
i_DM_ren  in  1  load request
i_DM_funct3  in  3  access size/sign, RV32I load/store encoding
o_DM_rd  out  32  load result, extended
o_stall  out  1  core must hold PC and all DM inputs
o_misaligned  out  1  one-cycle pulse: misaligned access or illegal funct3
o_bus_err  out  1  one-cycle pulse: bus error or timeout
o_BUS_req  out  1  request valid
o_BUS_we  out  1  1 = write
o_BUS_addr  out  32  word address; bits [1:0] always 0
o_BUS_wdata  out  32  lane-replicated write data
o_BUS_be  out  4  byte enables
i_BUS_gnt  in  1  request accepted
i_BUS_rvalid  in  1  response valid; one response per request, reads and writes
i_BUS_rdata  in  32  read data
i_BUS_err  in  1  error, qualified by i_BUS_rvalid

Behaviour:
- FSM states: IDLE, REQ, RSP, DONE. All bus outputs are registered.
- Reset: state IDLE. o_BUS_req, o_BUS_we, o_BUS_addr, o_BUS_wdata, o_BUS_be, o_DM_rd = 0. Pulses = 0.
- IDLE, access = wen|ren:
  - No access: stay IDLE, o_stall=0.
  - Aligned, legal access: o_stall=1 combinationally. Register addr&~3, we=wen, be, wdata. Go REQ with o_BUS_req=1.
  - Misaligned or illegal: no bus transaction. o_misaligned=1 for that cycle, o_stall=0, stay IDLE.
- wen and ren both high: treated as store.
- Misaligned: halfword (funct3 001/101) with addr[0]=1; word (010) with addr[1:0]≠0.
- Illegal funct3: 011, 110, 111; also 100/101 with wen.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- wdata: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- REQ: o_BUS_req held, outputs stable until i_BUS_gnt. On req&gnt edge: req←0, go RSP. o_stall=1.
- RSP: wait for i_BUS_rvalid. On rvalid: capture rdata and err, go DONE. o_stall=1.
  - rvalid seen in IDLE or REQ is ignored.
- DONE (one cycle): o_stall=0, so the core retires the access at this edge.
  - Load: o_DM_rd = lane selected by the captured addr[1:0], extended (000 LB sign, 001 LH sign, 100 LBU zero, 101 LHU zero, 010 LW).
  - Store: o_DM_rd unchanged.
  - Captured err=1: o_bus_err=1 and o_DM_rd=0.
  - Always returns to IDLE.
- o_DM_rd holds its value outside DONE.
- Minimum access latency: 4 cycles (IDLE, REQ with gnt, RSP with rvalid, DONE) = 3 stall cycles.
- Reset mid-transaction: next edge goes to IDLE with req=0. A late rvalid is ignored.

Optional Feature:
DM_BUS_TIMEOUT_EN
- Defined: an 8+ bit counter clears on IDLE→REQ and increments each cycle in REQ or RSP. When the count reaches TIMEOUT_CYCLES, the next edge forces DONE with req=0, o_bus_err=1 and o_DM_rd=0 for a load. A response arriving later is ignored.
- Undefined: no counter; the bridge waits indefinitely for gnt/rvalid.

Test Plan:
- LW addr 0x100, gnt same cycle as req, rvalid one cycle later with rdata 0xDEADBEEF → o_BUS_addr 0x100, be 1111, we 0; stall high exactly 3 cycles; DONE o_DM_rd=0xDEADBEEF.
- LB addr 0x103 with rdata 0x80112233 → be 1000, o_DM_rd=0xFFFFFF80. Same with LBU → 0x00000080.
- SH addr 0x202, wd 0x0000ABCD, gnt delayed 5 cycles → req held 5+ cycles with stable outputs; be 1100, wdata 0xABCDABCD, we 1; o_DM_rd unchanged.
- LW addr 0x101 → no o_BUS_req, o_misaligned pulse 1 cycle, o_stall=0. SB addr 0x101 → be 0010, no fault.
- LW, rvalid with i_BUS_err=1, rdata 0x12345678 → DONE o_bus_err=1, o_DM_rd=0. Then i_rst pulsed while in RSP → IDLE next cycle; a following rvalid is ignored, o_stall=0.
- With DM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, gnt never asserted → DONE after 4 REQ cycles, o_bus_err=1, req=0. Without the macro, stall persists for 100+ cycles.
